mem_port_arbiter: RTL

- Shares the single-port data/instruction RAM between two requesters: instruction fetch (IF) and the Memory stage (MEM).
- Grants one access at a time and drives the RAM port for one cycle.
- Waits a fixed RAM read latency, then returns data to the winner with a one-cycle valid pulse.
- Drives per-requester stall outputs to the pipeline control.

---
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : IF/MEM requester and RAM port bundle | Rev 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_valid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_stall;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  ram_rdata,
    output if_valid, if_rdata, if_stall,
    output mem_valid, mem_rdata, mem_stall,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  // Requester / RAM side
  modport master (
    output if_req, if_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output ram_rdata,
    input  if_valid, if_rdata, if_stall,
    input  mem_valid, mem_rdata, mem_stall,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one RAM port between IF and MEM, MEM-first priority.
// Optional IF anti-starvation enabled by MEM_ARB_FAIR_EN.           | Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  wire logic          clk_i,
  input  wire logic          reset_i,
  mem_port_arbiter_if.slave  port
);

  localparam int             CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  if (LATENCY < 1 || LATENCY > 15 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_param_check
    $error("mem_port_arbiter: LATENCY and STARVE_MAX must lie in 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e              state_q;
  logic                owner_mem_q;
  logic                we_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                ram_en_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic                if_valid_q;
  logic                mem_valid_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   mem_rdata_q;

  logic                if_wins;
  logic                grant_mem_d;
  logic                grant_if_d;

`ifdef MEM_ARB_FAIR_EN
  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);
  logic [CNT_W-1:0]    starve_q;

  // Counts MEM grants taken while IF was also waiting
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      starve_q <= '0;
    end else if (state_q == ST_IDLE) begin
      if (!port.if_req || grant_if_d) begin
        starve_q <= '0;
      end else if (grant_mem_d) begin
        starve_q <= starve_q + CNT_ONE;
      end
    end
  end

  always_comb begin
    if_wins = port.if_req && (starve_q == STARVE_CNT);
  end
`else
  always_comb begin
    if_wins = 1'b0;
  end
`endif

  always_comb begin
    grant_mem_d = port.mem_req && !if_wins;
    grant_if_d  = port.if_req && !grant_mem_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      wait_cnt_q  <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_mem_d || grant_if_d) begin
            owner_mem_q <= grant_mem_d;
            we_q        <= grant_mem_d && port.mem_we;
            ram_en_q    <= 1'b1;
            ram_we_q    <= grant_mem_d && port.mem_we;
            ram_addr_q  <= grant_mem_d ? port.mem_addr : port.if_addr;
            if (grant_mem_d) begin
              ram_wdata_q <= port.mem_wdata;
            end
            state_q     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          wait_cnt_q <= LAT_CNT;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          wait_cnt_q <= wait_cnt_q - CNT_ONE;
          // Last wait cycle: ram_rdata is valid now, so valid lands in RESP
          if (wait_cnt_q == CNT_ONE) begin
            if (owner_mem_q) begin
              mem_valid_q <= 1'b1;
              if (!we_q) begin
                mem_rdata_q <= port.ram_rdata;
              end
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= port.ram_rdata;
            end
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign port.ram_en    = ram_en_q;
  assign port.ram_we    = ram_we_q;
  assign port.ram_addr  = ram_addr_q;
  assign port.ram_wdata = ram_wdata_q;
  assign port.if_valid  = if_valid_q;
  assign port.if_rdata  = if_rdata_q;
  assign port.mem_valid = mem_valid_q;
  assign port.mem_rdata = mem_rdata_q;
  assign port.if_stall  = port.if_req  & ~if_valid_q;
  assign port.mem_stall = port.mem_req & ~mem_valid_q;

endmodule

`default_nettype wire
